pll_lock_sequencer: RTL and testbench
=====================================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RESET_PULSE_CYCLES, default 16: cycles a PLL RESETB is held low per reset attempt (range 1..65535).
REQ-002 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized lock-high cycles required to accept a lock (range 1..65535).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 60000: maximum cycles spent waiting for a lock (range > STABLE_CYCLES, max 65535).
REQ-004 gen_12mhz  input  1  free-running 12 MHz board oscillator; sole clock, all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 pll1_lock  input  1  LOCK from first PLL, asynchronous.
REQ-007 pll2_lock  input  1  LOCK from second PLL, asynchronous.
REQ-008 pll1_resetb  output  1  drives RESETB of first PLL.
REQ-009 pll2_resetb  output  1  drives RESETB of second PLL.
REQ-010 sys_rst_n  output  1  active-low reset for logic in PLL-generated domains; 1 only in RUN.
REQ-011 ready  output  1  high only in RUN.
REQ-012 fault  output  1  sticky lock-timeout flag.
REQ-013 state_dbg  output  3  current state encoding.

Function
REQ-014 pll1_lock and pll2_lock SHALL each pass a 2-flop synchronizer (s1, s2); all decisions use s1/s2, giving 2-cycle input latency.
REQ-015 States and encodings SHALL be: PLL1_RST=0, PLL1_WAIT=1, PLL2_WAIT=2, RUN=3, PLL2_RST=4, FAULT=5; codes 6/7 SHALL go to PLL1_RST next cycle.
REQ-016 Outputs SHALL be registered and decoded from state: pll1_resetb=1 in states 1,2,3,4; pll2_resetb=1 in states 2,3; sys_rst_n=ready=1 in state 3 only.
REQ-017 PLL1_RST and PLL2_RST SHALL count RESET_PULSE_CYCLES cycles, then go to PLL1_WAIT and PLL2_WAIT respectively.
REQ-018 In PLL1_WAIT a stable counter SHALL increment each cycle s1=1 and clear when s1=0; at STABLE_CYCLES consecutive highs go to PLL2_WAIT.
REQ-019 In PLL2_WAIT the stable counter SHALL track s2 identically; at STABLE_CYCLES go to RUN; s1=0 SHALL go to PLL1_RST.
REQ-020 A timeout counter SHALL clear on entry to each WAIT state and increment every cycle in it; reaching TIMEOUT_CYCLES SHALL go to FAULT.
REQ-021 Priorities in one cycle: s1 drop > stable-count reached > timeout.
REQ-022 In RUN: s1=0 -> PLL1_RST; else s2=0 -> PLL2_RST; sys_rst_n and ready fall the cycle after the transition.
REQ-023 FAULT SHALL hold both RESETBs low, set fault=1, wait TIMEOUT_CYCLES, then go to PLL1_RST for retry; fault stays 1 until rst_n=0.
REQ-024 Counters SHALL be 16 bits, saturating, cleared on every state change.

Reset
REQ-025 While rst_n=0 at a clock edge: state=PLL1_RST, counters=0, synchronizers=0, pll1_resetb=0, pll2_resetb=0, sys_rst_n=0, ready=0, fault=0, state_dbg=0.
REQ-026 Reset asserted mid-operation, including RUN and FAULT, SHALL take effect on the next edge and restart the full sequence.

Configuration
REQ-027 With LOCK_LOSS_COUNT_EN defined: output loss_count [7:0], reset 0, increments by 1 on each exit from RUN caused by lock loss, saturates at 255, cleared only by rst_n.
REQ-028 Without LOCK_LOSS_COUNT_EN: port loss_count and its logic SHALL be absent; all other behaviour identical.

Verification (RESET_PULSE_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=100)
REQ-029 rst_n low 3 cycles then high, pll1_lock rises at cycle 10, pll2_lock rises 20 cycles after pll2_resetb rises -> pll1_resetb high at cycle 4, PLL2_WAIT entered 10 cycles after pll1_lock rises (2 sync + 8 stable), ready=1 10 cycles after pll2_lock rises.
REQ-030 In PLL1_WAIT pulse pll1_lock low 1 cycle after 6 high cycles -> stable count restarts; PLL2_WAIT entered only after 8 further consecutive highs.
REQ-031 pll1_lock held low -> FAULT after 100 cycles in PLL1_WAIT, fault=1, retry PLL1_RST 100 cycles later, fault still 1.
REQ-032 In RUN drop pll2_lock -> state 4, pll2_resetb low 4 cycles, pll1_resetb stays 1, loss_count=1 when LOCK_LOSS_COUNT_EN defined.
REQ-033 In RUN drop both locks in the same cycle -> PLL1_RST (not PLL2_RST); 300 lock losses -> loss_count=255.
REQ-034 rst_n low for one cycle while in RUN -> all outputs at reset values next edge, full sequence repeats.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// Brings up two cascaded PLLs in order and releases the downstream reset only once both locks are stable.
// Latency: 2-cycle lock synchronizer; outputs are registered and change on the same edge as the state.
// Backpressure: none. Optional LOCK_LOSS_COUNT_EN adds the loss_count port.
module pll_lock_sequencer #(
    parameter int unsigned RESET_PULSE_CYCLES = 16,
    parameter int unsigned STABLE_CYCLES      = 1024,
    parameter int unsigned TIMEOUT_CYCLES     = 60000
) (
    input  logic       gen_12mhz,
    input  logic       rst_n,
    input  logic       pll1_lock,
    input  logic       pll2_lock,
    output logic       pll1_resetb,
    output logic       pll2_resetb,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state_dbg
`ifdef LOCK_LOSS_COUNT_EN
    ,
    output logic [7:0] loss_count
`endif
);

    typedef enum logic [2:0] {
        PLL1_RST  = 3'd0,
        PLL1_WAIT = 3'd1,
        PLL2_WAIT = 3'd2,
        RUN       = 3'd3,
        PLL2_RST  = 3'd4,
        FAULT     = 3'd5
    } state_t;

    localparam logic [15:0] RST_LAST    = 16'(RESET_PULSE_CYCLES - 1);
    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] TO_LAST     = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        p1_meta_q, s1_q, p2_meta_q, s2_q;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] stable_q, stable_d;
    logic [15:0] cnt_inc, stable_inc;
    logic        pll1_resetb_q, pll1_resetb_d;
    logic        pll2_resetb_q, pll2_resetb_d;
    logic        run_q, run_d;
    logic        fault_q, fault_d;
    logic        lock_lost;

    always_comb begin
        state_d    = state_q;
        cnt_inc    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        stable_inc = (stable_q == 16'hFFFF) ? stable_q : stable_q + 16'd1;
        cnt_d      = cnt_inc;
        stable_d   = stable_q;
        lock_lost  = 1'b0;

        case (state_q)
            PLL1_RST: begin
                if (cnt_q == RST_LAST) state_d = PLL1_WAIT;
            end
            PLL1_WAIT: begin
                stable_d = s1_q ? stable_inc : 16'd0;
                if (s1_q && stable_q == STABLE_LAST) state_d = PLL2_WAIT;
                else if (cnt_q == TO_LAST)           state_d = FAULT;
            end
            PLL2_WAIT: begin
                stable_d = s2_q ? stable_inc : 16'd0;
                // Losing PLL1 beats both stability and timeout: PLL2 is clocked from it.
                if (!s1_q)                                state_d = PLL1_RST;
                else if (s2_q && stable_q == STABLE_LAST) state_d = RUN;
                else if (cnt_q == TO_LAST)                state_d = FAULT;
            end
            RUN: begin
                if (!s1_q) begin
                    state_d   = PLL1_RST;
                    lock_lost = 1'b1;
                end else if (!s2_q) begin
                    state_d   = PLL2_RST;
                    lock_lost = 1'b1;
                end
            end
            PLL2_RST: begin
                if (cnt_q == RST_LAST) state_d = PLL2_WAIT;
            end
            FAULT: begin
                if (cnt_q == TO_LAST) state_d = PLL1_RST;
            end
            default: state_d = PLL1_RST;
        endcase

        if (state_d != state_q) begin
            cnt_d    = 16'd0;
            stable_d = 16'd0;
        end

        // Outputs decode the next state so they switch on the same edge as state_q.
        pll1_resetb_d = (state_d == PLL1_WAIT) || (state_d == PLL2_WAIT) ||
                        (state_d == RUN)       || (state_d == PLL2_RST);
        pll2_resetb_d = (state_d == PLL2_WAIT) || (state_d == RUN);
        run_d         = (state_d == RUN);
        fault_d       = fault_q || (state_d == FAULT);
    end

    always_ff @(posedge gen_12mhz) begin
        if (!rst_n) begin
            state_q       <= PLL1_RST;
            p1_meta_q     <= 1'b0;
            s1_q          <= 1'b0;
            p2_meta_q     <= 1'b0;
            s2_q          <= 1'b0;
            cnt_q         <= 16'd0;
            stable_q      <= 16'd0;
            pll1_resetb_q <= 1'b0;
            pll2_resetb_q <= 1'b0;
            run_q         <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            p1_meta_q     <= pll1_lock;
            s1_q          <= p1_meta_q;
            p2_meta_q     <= pll2_lock;
            s2_q          <= p2_meta_q;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            pll1_resetb_q <= pll1_resetb_d;
            pll2_resetb_q <= pll2_resetb_d;
            run_q         <= run_d;
            fault_q       <= fault_d;
        end
    end

`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] loss_count_q, loss_count_d;

    always_comb begin
        loss_count_d = loss_count_q;
        if (lock_lost && loss_count_q != 8'hFF) loss_count_d = loss_count_q + 8'd1;
    end

    always_ff @(posedge gen_12mhz) begin
        if (!rst_n) loss_count_q <= 8'd0;
        else        loss_count_q <= loss_count_d;
    end

    assign loss_count = loss_count_q;
`endif

    assign pll1_resetb = pll1_resetb_q;
    assign pll2_resetb = pll2_resetb_q;
    assign sys_rst_n   = run_q;
    assign ready       = run_q;
    assign fault       = fault_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed and randomized bench for pll_lock_sequencer against a cycle-level behavioural model.
module tb_pll_lock_sequencer;

    localparam int RP = 4;
    localparam int ST = 8;
    localparam int TO = 100;

    localparam int P1RST = 0, P1WAIT = 1, P2WAIT = 2, PRUN = 3, P2RST = 4, PFAULT = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       l1 = 1'b0;
    logic       l2 = 1'b0;
    logic       pll1_resetb, pll2_resetb, sys_rst_n, ready, fault;
    logic [2:0] state_dbg;
`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] loss_count;
`endif

    int tests = 0;
    int fails = 0;

    pll_lock_sequencer #(
        .RESET_PULSE_CYCLES(RP),
        .STABLE_CYCLES     (ST),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .gen_12mhz  (clk),
        .rst_n      (rst_n),
        .pll1_lock  (l1),
        .pll2_lock  (l2),
        .pll1_resetb(pll1_resetb),
        .pll2_resetb(pll2_resetb),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .fault      (fault),
        .state_dbg  (state_dbg)
`ifdef LOCK_LOSS_COUNT_EN
        ,
        .loss_count (loss_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: phase, time spent in phase, run of consecutive highs, lock history.
    int       m_phase   = P1RST;
    int       m_elapsed = 0;
    int       m_highs   = 0;
    int       m_loss    = 0;
    bit       m_fault   = 1'b0;
    bit [1:0] h1 = 2'b00;
    bit [1:0] h2 = 2'b00;

    task automatic model_edge();
        bit s1, s2;
        int nxt;
        if (!rst_n) begin
            m_phase = P1RST; m_elapsed = 0; m_highs = 0; m_loss = 0;
            m_fault = 1'b0;  h1 = 2'b00;    h2 = 2'b00;
        end else begin
            s1 = h1[1];
            s2 = h2[1];
            h1 = {h1[0], l1};
            h2 = {h2[0], l2};
            nxt = m_phase;
            m_elapsed++;
            case (m_phase)
                P1RST:  if (m_elapsed == RP) nxt = P1WAIT;
                P2RST:  if (m_elapsed == RP) nxt = P2WAIT;
                PFAULT: if (m_elapsed == TO) nxt = P1RST;
                P1WAIT: begin
                    m_highs = s1 ? m_highs + 1 : 0;
                    if (m_highs == ST)        nxt = P2WAIT;
                    else if (m_elapsed == TO) nxt = PFAULT;
                end
                P2WAIT: begin
                    if (!s1) nxt = P1RST;
                    else begin
                        m_highs = s2 ? m_highs + 1 : 0;
                        if (m_highs == ST)        nxt = PRUN;
                        else if (m_elapsed == TO) nxt = PFAULT;
                    end
                end
                PRUN: begin
                    if (!s1)      nxt = P1RST;
                    else if (!s2) nxt = P2RST;
                    if (nxt != PRUN && m_loss < 255) m_loss++;
                end
                default: nxt = P1RST;
            endcase
            if (nxt != m_phase) begin
                m_phase = nxt; m_elapsed = 0; m_highs = 0;
                if (nxt == PFAULT) m_fault = 1'b1;
            end
        end
    endtask

    function automatic logic [7:0] model_vec();
        logic r1, r2, rd;
        r1 = (m_phase == P1WAIT) || (m_phase == P2WAIT) || (m_phase == PRUN) || (m_phase == P2RST);
        r2 = (m_phase == P2WAIT) || (m_phase == PRUN);
        rd = (m_phase == PRUN);
        return {1'b0, 3'(m_phase), r1, r2, rd, rd} ^ {7'd0, 1'b0} | {7'd0, m_fault} << 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("outputs_vs_model",
            {24'd0, state_dbg, pll1_resetb, pll2_resetb, sys_rst_n, ready, fault},
            {24'd0, 3'(m_phase),
             1'((m_phase == P1WAIT) || (m_phase == P2WAIT) || (m_phase == PRUN) || (m_phase == P2RST)),
             1'((m_phase == P2WAIT) || (m_phase == PRUN)),
             1'(m_phase == PRUN), 1'(m_phase == PRUN), m_fault});
`ifdef LOCK_LOSS_COUNT_EN
        chk("loss_count_vs_model", {24'd0, loss_count}, m_loss);
`endif
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic steps_until(input logic [2:0] code, input int budget, output int n);
        n = 0;
        while (state_dbg !== code && n < budget) begin
            step();
            n++;
        end
        chk("wait_state_reached", {29'd0, state_dbg}, {29'd0, code});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;

        // Power-up: reset held for three cycles.
        rst_n = 1'b0; l1 = 1'b0; l2 = 1'b0;
        steps(3);
        chk("reset_state_dbg", {29'd0, state_dbg}, 0);
        chk("reset_outputs", {27'd0, pll1_resetb, pll2_resetb, sys_rst_n, ready, fault}, 0);

        // Nominal bring-up.
        rst_n = 1'b1;
        steps_until(3'd1, 20, n);
        chk("pll1_resetb_rise_cycles", n, RP);
        chk("pll1_resetb_high", {31'd0, pll1_resetb}, 1);
        steps(3);
        l1 = 1'b1;
        steps_until(3'd2, 50, n);
        chk("pll2_wait_latency", n, 2 + ST);
        chk("pll2_resetb_high", {31'd0, pll2_resetb}, 1);
        steps(20);
        l2 = 1'b1;
        steps_until(3'd3, 50, n);
        chk("ready_latency", n, 2 + ST);
        chk("ready_high", {30'd0, ready, sys_rst_n}, 3);

        // One-cycle reset while running restarts everything.
        rst_n = 1'b0;
        step();
        chk("mid_run_reset_state", {29'd0, state_dbg}, 0);
        chk("mid_run_reset_outputs", {27'd0, pll1_resetb, pll2_resetb, sys_rst_n, ready, fault}, 0);
        rst_n = 1'b1;
        steps_until(3'd3, 100, n);
        chk("rerun_to_ready_cycles", n, RP + 2 * ST);

        // PLL2 lock loss in RUN.
        l2 = 1'b0;
        steps_until(3'd4, 10, n);
        chk("pll2_loss_latency", n, 3);
        chk("pll2_loss_resetbs", {30'd0, pll1_resetb, pll2_resetb}, 2);
        chk("pll2_loss_not_ready", {31'd0, ready}, 0);
`ifdef LOCK_LOSS_COUNT_EN
        chk("loss_count_one", {24'd0, loss_count}, 1);
`endif
        steps_until(3'd2, 10, n);
        chk("pll2_rst_length", n, RP);
        l2 = 1'b1;
        steps_until(3'd3, 50, n);
        chk("pll2_relock_cycles", n, 2 + ST);

        // Both locks drop together: PLL1 path wins.
        l1 = 1'b0; l2 = 1'b0;
        steps_until(3'd0, 10, n);
        chk("both_drop_to_pll1_rst", n, 3);
        l1 = 1'b1; l2 = 1'b1;
        steps_until(3'd3, 100, n);
        chk("both_relock_cycles", n, RP + 2 * ST);

        // Repeated PLL2 losses saturate the counter.
        for (int k = 0; k < 300; k++) begin
            l2 = 1'b0;
            steps_until(3'd4, 10, n);
            l2 = 1'b1;
            steps_until(3'd3, 50, n);
        end
        chk("ready_after_loss_loop", {31'd0, ready}, 1);
`ifdef LOCK_LOSS_COUNT_EN
        chk("loss_count_saturated", {24'd0, loss_count}, 255);
`endif

        // Glitch on PLL1 lock restarts the stability window.
        l1 = 1'b0; l2 = 1'b0;
        do_reset();
        steps_until(3'd1, 20, n);
        l1 = 1'b1;
        steps(6);
        l1 = 1'b0;
        step();
        chk("glitch_still_pll1_wait", {29'd0, state_dbg}, 1);
        l1 = 1'b1;
        steps_until(3'd2, 50, n);
        chk("glitch_restart_cycles", n, 2 + ST);

        // PLL1 never locks: timeout, fault, retry.
        l1 = 1'b0; l2 = 1'b0;
        do_reset();
        steps_until(3'd1, 20, n);
        steps_until(3'd5, 200, n);
        chk("timeout_cycles", n, TO);
        chk("fault_set", {31'd0, fault}, 1);
        chk("fault_resetbs_low", {30'd0, pll1_resetb, pll2_resetb}, 0);
        steps_until(3'd0, 200, n);
        chk("fault_hold_cycles", n, TO);
        chk("fault_sticky", {31'd0, fault}, 1);
        rst_n = 1'b0;
        step();
        chk("fault_cleared_by_reset", {31'd0, fault}, 0);
        rst_n = 1'b1;

        // Randomized lock activity with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (l1) begin if ($urandom_range(59, 0) == 0) l1 = 1'b0; end
            else    begin if ($urandom_range(7, 0) == 0)  l1 = 1'b1; end
            if (l2) begin if ($urandom_range(59, 0) == 0) l2 = 1'b0; end
            else    begin if ($urandom_range(7, 0) == 0)  l2 = 1'b1; end
            rst_n = ($urandom_range(499, 0) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
